// File: rtl/i2c_phase_timer_pkg.sv
// Shared definitions for the I2C phase timer: run-mode encodings and FSM states.
package i2c_phase_timer_pkg;

  // Run modes as seen on the mode input and held in the mode shadow register
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Timer control states: idle until started, running until a burst completes
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/i2c_tick_counter.sv
// Loadable down-counter with hold. The zero flag marks the final tick of a phase.
module i2c_tick_counter
  import i2c_phase_timer_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [SIZE-1:0] load_val,
  input  logic            en,
  output logic            zero
);

  logic [SIZE-1:0] cnt_reg;

  // Load has priority; otherwise count down while enabled and stop at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - SIZE'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/i2c_phase_timer.sv
// I2C phase timer: splits each bit into NPHASE timed phases (low half, then high
// half), pulses at each phase and bit end, freezes on stop, periodic or one-shot.
module i2c_phase_timer
  import i2c_phase_timer_pkg::*;
#(
  parameter int SIZE   = 8,
  parameter int NPHASE = 4,
  parameter int BW     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      mode,
  input  logic [SIZE-1:0]           ticks_low,
  input  logic [SIZE-1:0]           ticks_high,
  input  logic [BW-1:0]             bits,
  output logic                      out,
  output logic                      bit_done,
  output logic                      done,
  output logic                      busy,
  output logic [$clog2(NPHASE)-1:0] phase
);

  localparam int PW = $clog2(NPHASE);
  localparam logic [PW-1:0] LAST_PHASE = PW'(NPHASE - 1);

  timer_state_e    state_reg, state_next;

  logic [SIZE-1:0] low_sh_reg;
  logic [SIZE-1:0] high_sh_reg;
  logic            mode_sh_reg;
  logic [BW-1:0]   bits_sh_reg;

  logic [PW-1:0]   phase_reg;
  logic [BW-1:0]   bit_cnt_reg;
  logic            out_reg;
  logic            bit_done_reg;
  logic            done_reg;

  logic            run_en;
  logic            cnt_zero;
  logic            phase_end;
  logic            last_phase;
  logic [PW-1:0]   new_phase;
  logic [BW-1:0]   eff_bits;
  logic            final_bit;
  logic            burst_end;
  logic            cnt_load;
  logic [SIZE-1:0] cnt_load_val;
  logic [SIZE-1:0] phase_ticks [NPHASE];

  // Per-phase tick table: first half of the bit uses the low count, second half the high
  for (genvar gi = 0; gi < NPHASE; gi++) begin : g_phase_ticks
    if (gi < NPHASE / 2) begin : g_low
      assign phase_ticks[gi] = low_sh_reg;
    end else begin : g_high
      assign phase_ticks[gi] = high_sh_reg;
    end
  end

  // Start takes the edge, so the counter only counts on edges without start or stop
  assign run_en     = busy && !stop && !start;
  assign phase_end  = run_en && cnt_zero;
  assign last_phase = (phase_reg == LAST_PHASE);
  assign new_phase  = last_phase ? '0 : phase_reg + PW'(1);
  assign eff_bits   = (bits_sh_reg == '0) ? BW'(1) : bits_sh_reg;
  assign final_bit  = (bit_cnt_reg == eff_bits - BW'(1));
  assign burst_end  = phase_end && last_phase && (mode_sh_reg == MODE_ONESHOT) && final_bit;

  // At the end of a burst the counter is left alone (already zero) while the timer idles
  assign cnt_load     = start || (phase_end && !burst_end);
  assign cnt_load_val = start ? ticks_low : phase_ticks[new_phase];

  i2c_tick_counter #(
    .SIZE(SIZE)
  ) u_tick_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (run_en),
    .zero     (cnt_zero)
  );

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: start (re)enters run from anywhere, a finished burst returns to idle
  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = ST_RUN;
    end else if (burst_end) begin
      state_next = ST_IDLE;
    end
  end

  // Shadow registers: configuration is sampled only on start
  always_ff @(posedge clk) begin
    if (rst) begin
      low_sh_reg  <= '0;
      high_sh_reg <= '0;
      mode_sh_reg <= MODE_PERIODIC;
      bits_sh_reg <= '0;
    end else if (start) begin
      low_sh_reg  <= ticks_low;
      high_sh_reg <= ticks_high;
      mode_sh_reg <= mode;
      bits_sh_reg <= bits;
    end
  end

  // Phase and bit counters advance on each phase end; the last phase wraps to 0
  always_ff @(posedge clk) begin
    if (rst || start) begin
      phase_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (phase_end) begin
      phase_reg <= new_phase;
      if (last_phase) begin
        bit_cnt_reg <= bit_cnt_reg + BW'(1);
      end
    end
  end

  // Registered single-cycle pulses; a restart suppresses any pulse on that edge
  always_ff @(posedge clk) begin
    if (rst || start) begin
      out_reg      <= 1'b0;
      bit_done_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      out_reg      <= phase_end;
      bit_done_reg <= phase_end && last_phase;
      done_reg     <= burst_end;
    end
  end

  assign out      = out_reg;
  assign bit_done = bit_done_reg;
  assign done     = done_reg;
  assign busy     = (state_reg == ST_RUN);
  assign phase    = phase_reg;

endmodule
